// File: rtl/rd_ctrl_if.sv
// Read-controller bundle: processor read port, access-list lookup, line fill,
// line-memory read and the read/write hazard status exchange.
interface rd_ctrl_if #(
  parameter int addr_width = 32,
  parameter int data_width = 32,
  parameter int list_depth = 4,
  parameter int list_width = 32
);
  localparam int TW = $clog2(list_depth);
  localparam int OW = $clog2(list_width);

  logic                  rd_valid;
  logic                  rd_ready;
  logic [addr_width-1:0] rd_addr;
  logic                  rd_resp_valid;
  logic                  rd_resp_ready;
  logic [data_width-1:0] rd_data;

  logic                  acc_req;
  logic [1:0]            acc_cmd;
  logic [addr_width-1:0] acc_index;
  logic [2:0]            acc_status;
  logic [TW-1:0]         return_tag;

  logic [2:0]            proc_status_w;
  logic [addr_width-1:0] proc_addr_w;
  logic [2:0]            proc_status_r;
  logic [addr_width-1:0] proc_addr_r;

  logic                  fetch_req;
  logic [1:0]            fetch_cmd;
  logic [TW-1:0]         fetch_tag;
  logic [addr_width-1:0] fetch_addr;
  logic                  fetch_gnt;
  logic                  fetch_done;

  logic [TW+OW-1:0]      mem_raddr;
  logic                  mem_ren;
  logic                  mem_rvalid;
  logic [data_width-1:0] mem_rdata;

  // the read controller itself
  modport slave (
    input  rd_valid, rd_addr, rd_resp_ready, acc_status, return_tag,
           proc_status_w, proc_addr_w, fetch_gnt, fetch_done, mem_rvalid, mem_rdata,
    output rd_ready, rd_resp_valid, rd_data, acc_req, acc_cmd, acc_index,
           proc_status_r, proc_addr_r, fetch_req, fetch_cmd, fetch_tag, fetch_addr,
           mem_raddr, mem_ren
  );

  // processor, access list, fill engine, line memory and write controller
  modport master (
    output rd_valid, rd_addr, rd_resp_ready, acc_status, return_tag,
           proc_status_w, proc_addr_w, fetch_gnt, fetch_done, mem_rvalid, mem_rdata,
    input  rd_ready, rd_resp_valid, rd_data, acc_req, acc_cmd, acc_index,
           proc_status_r, proc_addr_r, fetch_req, fetch_cmd, fetch_tag, fetch_addr,
           mem_raddr, mem_ren
  );
endinterface

// File: rtl/rd_ctrl.sv
// Cache read-side controller: one read in flight, hazard stall against the
// write controller, access-list lookup, optional line fill, word read, response.
module rd_ctrl #(
  parameter int addr_width = 32,
  parameter int data_width = 32,
  parameter int list_depth = 4,
  parameter int list_width = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  rd_ctrl_if.slave    bus
);
  localparam int AW = addr_width;
  localparam int TW = $clog2(list_depth);
  localparam int OW = $clog2(list_width);

  localparam logic [2:0] ACC_HIT  = 3'b001;
  localparam logic [2:0] ACC_MISS = 3'b010;
  localparam logic [2:0] ACC_BUSY = 3'b100;

  // encoding doubles as the published proc_status_r value
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    HAZ        = 3'd1,
    LOOKUP     = 3'd2,
    FETCH      = 3'd3,
    FETCH_WAIT = 3'd4,
    MEM_RD     = 3'd5,
    MEM_WAIT   = 3'd6,
    RESP       = 3'd7
  } state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [TW-1:0]         tag_q, tag_d;
  logic [data_width-1:0] data_q, data_d;
  logic                  line_conflict;
  logic                  unused_addr_lo;

  // hazards are tracked per line, so the write offset does not matter
  assign unused_addr_lo = ^bus.proc_addr_w[OW-1:0];
  assign line_conflict  = (bus.proc_status_w != 3'b000) &&
                          (bus.proc_addr_w[AW-1:OW] == addr_q[AW-1:OW]);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tag_d   = tag_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (bus.rd_valid) begin
          addr_d  = bus.rd_addr;
          state_d = HAZ;
        end
      end
      HAZ: begin
        if (!line_conflict) state_d = LOOKUP;
      end
      LOOKUP: begin
        case (bus.acc_status)
          ACC_HIT: begin
            tag_d   = bus.return_tag;
            state_d = MEM_RD;
          end
          ACC_MISS: begin
            tag_d   = bus.return_tag;
            state_d = FETCH;
          end
          // back off through HAZ so acc_req drops between attempts
          ACC_BUSY: state_d = HAZ;
          default:  state_d = LOOKUP;
        endcase
      end
      FETCH: begin
        if (bus.fetch_gnt) state_d = bus.fetch_done ? MEM_RD : FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (bus.fetch_done) state_d = MEM_RD;
      end
      MEM_RD: state_d = MEM_WAIT;
      MEM_WAIT: begin
        if (bus.mem_rvalid) begin
          data_d  = bus.mem_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rd_resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  // Moore decode; everything is held at zero while reset is asserted
  always_comb begin
    bus.rd_ready      = 1'b0;
    bus.rd_resp_valid = 1'b0;
    bus.rd_data       = '0;
    bus.acc_req       = 1'b0;
    bus.acc_cmd       = 2'b00;
    bus.acc_index     = '0;
    bus.proc_status_r = 3'b000;
    bus.proc_addr_r   = '0;
    bus.fetch_req     = 1'b0;
    bus.fetch_cmd     = 2'b00;
    bus.fetch_tag     = '0;
    bus.fetch_addr    = '0;
    bus.mem_raddr     = '0;
    bus.mem_ren       = 1'b0;
    if (rst_n) begin
      bus.rd_data       = data_q;
      bus.proc_status_r = state_q;
      if (state_q != IDLE) bus.proc_addr_r = addr_q;
      case (state_q)
        IDLE: bus.rd_ready = 1'b1;
        LOOKUP: begin
          bus.acc_req   = 1'b1;
          bus.acc_cmd   = 2'b01;
          bus.acc_index = AW'(addr_q[AW-1:OW]);
        end
        FETCH: begin
          bus.fetch_req  = 1'b1;
          bus.fetch_cmd  = 2'b01;
          bus.fetch_tag  = tag_q;
          bus.fetch_addr = {addr_q[AW-1:OW], {OW{1'b0}}};
        end
        MEM_RD: begin
          bus.mem_ren   = 1'b1;
          bus.mem_raddr = {tag_q, addr_q[OW-1:0]};
        end
        RESP: bus.rd_resp_valid = 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rd_ctrl.sv
// Directed plus randomized reads against rd_ctrl; expectations come from a
// line-memory array and a per-read latency formula built from the state rules.
module tb_rd_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LD = 4;
  localparam int LW = 32;
  localparam int TW = $clog2(LD);
  localparam int OW = $clog2(LW);
  localparam int NW = 1 << (TW + OW);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rd_ctrl_if #(.addr_width(AW), .data_width(DW), .list_depth(LD), .list_width(LW)) bus ();

  rd_ctrl #(.addr_width(AW), .data_width(DW), .list_depth(LD), .list_width(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int nvec = 0;
  int nerr = 0;
  logic [DW-1:0] mem_arr [NW];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic any_out();
    return |{bus.rd_resp_valid, bus.rd_data, bus.acc_req, bus.acc_cmd, bus.acc_index,
             bus.proc_status_r, bus.proc_addr_r, bus.fetch_req, bus.fetch_cmd,
             bus.fetch_tag, bus.fetch_addr, bus.mem_raddr, bus.mem_ren};
  endfunction

  task automatic drive_idle();
    bus.rd_valid      = 1'b0;
    bus.rd_addr       = '0;
    bus.rd_resp_ready = 1'b0;
    bus.acc_status    = 3'b000;
    bus.return_tag    = '0;
    bus.proc_status_w = 3'b000;
    bus.proc_addr_w   = '0;
    bus.fetch_gnt     = 1'b0;
    bus.fetch_done    = 1'b0;
    bus.mem_rvalid    = 1'b0;
    bus.mem_rdata     = '0;
  endtask

  // a completed fill replaces the whole line in the memory model
  task automatic fill(input logic [TW-1:0] t);
    for (int o = 0; o < LW; o++) mem_arr[(int'(t) << OW) + o] = $urandom;
  endtask

  task automatic recover();
    drive_idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One read, called at a negedge with the block idle. The bench plays access
  // list (pd pending cycles, nb busy answers), fill engine, memory and write side.
  task automatic run_read(input logic [AW-1:0] a, input int hs, input logic [AW-1:0] haz_a,
                          input int hz, input int nb, input int pd, input int miss,
                          input logic [TW-1:0] tg, input int gd, input int dd, input int sim,
                          input int ml, input int bp);
    int stall, exp_lat, cyc, lk, busy_left, att, fcyc, dwait, mwait, nren, bpc;
    logic prev_acc, prev_fetch, seen, fin, tmo;
    logic [TW+OW-1:0] ridx, widx;
    stall   = (hs != 0 && (haz_a >> OW) == (a >> OW)) ? hz : 0;
    exp_lat = (1 + stall) + nb * (pd + 2) + (pd + 1)
            + ((miss != 0) ? (gd + 1 + ((sim != 0) ? 0 : dd)) : 0) + 1 + ml + 1;
    widx = {tg, a[OW-1:0]};
    ridx = '0;
    if (hs != 0) begin
      bus.proc_status_w = 3'b010;
      bus.proc_addr_w   = haz_a;
    end
    chk("idle_ready", bus.rd_ready, 1);
    bus.rd_valid = 1'b1;
    bus.rd_addr  = a;
    @(negedge clk);
    bus.rd_valid = 1'b0;
    bus.rd_addr  = $urandom;
    chk("accept_status", bus.proc_status_r, 3'd1);
    chk("accept_addr_r", bus.proc_addr_r, a);
    chk("accept_not_ready", bus.rd_ready, 0);
    cyc = 1; lk = 0; busy_left = nb; att = 0; fcyc = 0; dwait = 0; mwait = 0; nren = 0; bpc = 0;
    prev_acc = 1'b0; prev_fetch = 1'b0; seen = 1'b0; fin = 1'b0; tmo = 1'b0;
    while (!fin) begin
      bus.proc_status_w = (hs != 0 && cyc <= hz) ? 3'b010 : 3'b000;
      if (cyc <= stall) chk("haz_hold_acc", bus.acc_req, 0);

      bus.acc_status = 3'b000;
      bus.return_tag = TW'($urandom);
      if (bus.acc_req) begin
        if (!prev_acc) begin
          att++;
          chk("acc_cmd", bus.acc_cmd, 2'b01);
          chk("acc_index", bus.acc_index, a >> OW);
        end
        if (lk < pd) lk++;
        else begin
          lk = 0;
          if (busy_left > 0) begin
            busy_left--;
            bus.acc_status = 3'b100;
          end else begin
            bus.acc_status = (miss != 0) ? 3'b010 : 3'b001;
            bus.return_tag = tg;
          end
        end
      end
      prev_acc = bus.acc_req;

      bus.fetch_gnt  = 1'b0;
      bus.fetch_done = 1'b0;
      if (bus.fetch_req) begin
        if (!prev_fetch) begin
          chk("fetch_addr", bus.fetch_addr, a & ~(AW'(LW - 1)));
          chk("fetch_tag", bus.fetch_tag, tg);
          chk("fetch_cmd", bus.fetch_cmd, 2'b01);
        end
        if (fcyc == gd) begin
          bus.fetch_gnt = 1'b1;
          if (sim != 0) begin
            bus.fetch_done = 1'b1;
            fill(tg);
          end else dwait = dd;
        end
        fcyc++;
      end else if (dwait > 0) begin
        dwait--;
        if (dwait == 0) begin
          bus.fetch_done = 1'b1;
          fill(tg);
        end
      end
      prev_fetch = bus.fetch_req;

      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = $urandom;
      if (mwait > 0) begin
        mwait--;
        if (mwait == 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = mem_arr[ridx];
        end
      end
      if (bus.mem_ren) begin
        nren++;
        chk("mem_raddr", bus.mem_raddr, widx);
        ridx  = bus.mem_raddr;
        mwait = ml;
      end

      bus.rd_resp_ready = 1'b0;
      if (bus.rd_resp_valid) begin
        if (!seen) begin
          seen = 1'b1;
          chk("resp_latency", cyc, exp_lat);
        end
        chk("resp_data", bus.rd_data, mem_arr[widx]);
        chk("resp_not_ready", bus.rd_ready, 0);
        if (bpc >= bp) begin
          bus.rd_resp_ready = 1'b1;
          fin = 1'b1;
        end
        bpc++;
      end
      if (cyc > 400) begin
        chk("read_timeout", 0, 1);
        fin = 1'b1;
        tmo = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    drive_idle();
    if (tmo) recover();
    chk("ret_idle_ready", bus.rd_ready, 1);
    chk("ret_idle_status", bus.proc_status_r, 0);
    chk("ret_idle_addr_r", bus.proc_addr_r, 0);
    chk("resp_dropped", bus.rd_resp_valid, 0);
    chk("attempts", att, nb + 1);
    chk("mem_ren_count", nren, 1);
    chk("fetch_cycles", fcyc, (miss != 0) ? gd + 1 : 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a, ha;
    int hs, hit_line;
    drive_idle();
    for (int i = 0; i < NW; i++) mem_arr[i] = $urandom;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", any_out(), 0);
    chk("reset_ready", bus.rd_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", bus.rd_ready, 1);
    chk("post_reset_outputs", any_out(), 0);

    // hit, zero waits: 5-cycle response, word {2,3}
    mem_arr[{2'd2, 5'd3}] = 32'hDEAD_BEEF;
    run_read(32'h0000_0043, 0, '0, 0, 0, 0, 0, 2'd2, 0, 1, 0, 1, 0);
    // miss with gnt after 2 cycles and done 4 later
    run_read(32'h0000_0120, 0, '0, 0, 0, 0, 1, 2'd1, 2, 4, 0, 1, 0);
    // same-line write in flight stalls; different line does not
    run_read(32'h0000_0120, 1, 32'h0000_0125, 3, 0, 0, 0, 2'd1, 0, 1, 0, 1, 0);
    run_read(32'h0000_0120, 1, 32'h0000_0200, 3, 0, 0, 0, 2'd1, 0, 1, 0, 1, 0);
    // two busy answers then a hit, with pending cycles
    run_read(32'h0000_0AA5, 0, '0, 0, 2, 1, 0, 2'd3, 0, 1, 0, 2, 0);
    // backpressure 4 cycles plus simultaneous gnt/done
    run_read(32'h0003_0007, 0, '0, 0, 0, 1, 1, 2'd0, 1, 1, 1, 2, 4);

    // reset while waiting for a fill
    bus.rd_valid = 1'b1;
    bus.rd_addr  = 32'h0000_0140;
    @(negedge clk);
    bus.rd_valid = 1'b0;
    @(negedge clk);
    chk("rst_seq_lookup", bus.acc_req, 1);
    bus.acc_status = 3'b010;
    bus.return_tag = 2'd3;
    @(negedge clk);
    bus.acc_status = 3'b000;
    chk("rst_seq_fetch", bus.fetch_req, 1);
    bus.fetch_gnt = 1'b1;
    @(negedge clk);
    bus.fetch_gnt = 1'b0;
    chk("rst_seq_fetch_wait", bus.proc_status_r, 3'd4);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_outputs", any_out(), 0);
    chk("rst_mid_ready", bus.rd_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_ready", bus.rd_ready, 1);
    chk("rst_rel_outputs", any_out(), 0);
    bus.fetch_done = 1'b1;
    @(negedge clk);
    bus.fetch_done = 1'b0;
    chk("stale_done_ren", bus.mem_ren, 0);
    chk("stale_done_status", bus.proc_status_r, 0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = $urandom;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    chk("stale_rvalid_resp", bus.rd_resp_valid, 0);
    chk("stale_rvalid_ready", bus.rd_ready, 1);
    run_read(32'h0000_0140, 0, '0, 0, 0, 0, 1, 2'd3, 0, 2, 0, 1, 1);

    for (int n = 0; n < 30; n++) begin
      a        = $urandom;
      hs       = int'($urandom_range(0, 1));
      hit_line = int'($urandom_range(0, 1));
      ha       = hit_line != 0 ? {a[AW-1:OW], OW'($urandom)} : AW'($urandom);
      run_read(a, hs, ha, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
               int'($urandom_range(0, 2)), int'($urandom_range(0, 1)), TW'($urandom),
               int'($urandom_range(0, 3)), int'($urandom_range(1, 4)),
               int'($urandom_range(0, 1)), int'($urandom_range(1, 3)),
               int'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
